// File: rtl/axi_rw_arbiter.sv
// axi_rw_arbiter: shares one AXI4 master port between two requesters
// (m0 = icache refill, m1 = dcache / uncached device). One complete read
// (AR->R) or write (AW->W->B) transaction runs per grant.
// Optional feature macro: AXI_ARB_RR_EN selects round-robin tie-breaking;
// when it is undefined m1 always wins simultaneous requests.
module axi_rw_arbiter #(
   parameter int LINE_BEATS = 2,
   parameter int ID_W       = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            m0_req,
   input  logic            m0_wen,
   input  logic            m0_dev,
   input  logic [2:0]      m0_size,
   input  logic [31:0]     m0_addr,
   input  logic [127:0]    m0_wdata,
   input  logic [7:0]      m0_wstrb,
   output logic            m0_done,
   output logic [127:0]    m0_rdata,
   output logic            m0_err,
   input  logic            m1_req,
   input  logic            m1_wen,
   input  logic            m1_dev,
   input  logic [2:0]      m1_size,
   input  logic [31:0]     m1_addr,
   input  logic [127:0]    m1_wdata,
   input  logic [7:0]      m1_wstrb,
   output logic            m1_done,
   output logic [127:0]    m1_rdata,
   output logic            m1_err,
   output logic            aw_valid,
   input  logic            aw_ready,
   output logic [31:0]     aw_addr,
   output logic [ID_W-1:0] aw_id,
   output logic [7:0]      aw_len,
   output logic [2:0]      aw_size,
   output logic [1:0]      aw_burst,
   output logic            w_valid,
   input  logic            w_ready,
   output logic [63:0]     w_data,
   output logic [7:0]      w_strb,
   output logic            w_last,
   input  logic            b_valid,
   output logic            b_ready,
   input  logic [1:0]      b_resp,
   output logic            ar_valid,
   input  logic            ar_ready,
   output logic [31:0]     ar_addr,
   output logic [ID_W-1:0] ar_id,
   output logic [7:0]      ar_len,
   output logic [2:0]      ar_size,
   output logic [1:0]      ar_burst,
   input  logic            r_valid,
   output logic            r_ready,
   input  logic [63:0]     r_data,
   input  logic [1:0]      r_resp,
   input  logic            r_last
);

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

   state_t         state;
   logic           gnt;        // port currently being served
   logic           dev;        // current transaction is a single-beat device access
   logic           err_acc;    // OR of resp[1] seen so far
   logic [7:0]     cnt;        // beat counter (R: beats stored, W: beats presented)
   logic [127:0]   rbuf;
   logic [127:0]   rbuf_nxt;
   logic [127:0]   wbuf;       // remaining write beats, lowest beat in [63:0]

   logic           gnt_nxt;
   logic           sel_wen, sel_dev;
   logic [2:0]     sel_size;
   logic [31:0]    sel_addr, ax_addr;
   logic [127:0]   sel_wdata;
   logic [7:0]     sel_wstrb;
   logic [7:0]     ax_len;
   logic [2:0]     ax_size;

`ifdef AXI_ARB_RR_EN
   logic last_gnt;

   // remember the most recent grant so that ties alternate; m0 wins the first tie
   always_ff @(posedge clk or posedge rst)
      if (rst)                                   last_gnt <= 1'b1;
      else if (state == S_IDLE && (m0_req || m1_req)) last_gnt <= gnt_nxt;

   assign gnt_nxt = (m0_req && m1_req) ? ~last_gnt : m1_req;
`else
   assign gnt_nxt = m1_req;
`endif

   assign sel_wen   = gnt_nxt ? m1_wen   : m0_wen;
   assign sel_dev   = gnt_nxt ? m1_dev   : m0_dev;
   assign sel_size  = gnt_nxt ? m1_size  : m0_size;
   assign sel_addr  = gnt_nxt ? m1_addr  : m0_addr;
   assign sel_wdata = gnt_nxt ? m1_wdata : m0_wdata;
   assign sel_wstrb = gnt_nxt ? m1_wstrb : m0_wstrb;

   // line bursts are 16-byte aligned 64-bit INCR bursts; device accesses pass through
   assign ax_addr = sel_dev ? sel_addr : {sel_addr[31:4], 4'h0};
   assign ax_len  = sel_dev ? 8'd0 : 8'(LINE_BEATS - 1);
   assign ax_size = sel_dev ? sel_size : 3'd3;

   // read buffer with the beat currently on the R channel merged in;
   // beats past the line length are dropped
   always_comb begin
      rbuf_nxt = rbuf;
      for (int k = 0; k < 2; k++)
         if (k < LINE_BEATS && cnt == 8'(k)) rbuf_nxt[k*64 +: 64] = r_data;
   end

   // transaction FSM; every AXI and requester output is a register of this block
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         gnt      <= 1'b0;
         dev      <= 1'b0;
         err_acc  <= 1'b0;
         cnt      <= '0;
         rbuf     <= '0;
         wbuf     <= '0;
         m0_done  <= 1'b0;
         m1_done  <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
         m0_err   <= 1'b0;
         m1_err   <= 1'b0;
         aw_valid <= 1'b0;
         aw_addr  <= '0;
         aw_id    <= '0;
         aw_len   <= '0;
         aw_size  <= '0;
         aw_burst <= '0;
         w_valid  <= 1'b0;
         w_data   <= '0;
         w_strb   <= '0;
         w_last   <= 1'b0;
         b_ready  <= 1'b0;
         ar_valid <= 1'b0;
         ar_addr  <= '0;
         ar_id    <= '0;
         ar_len   <= '0;
         ar_size  <= '0;
         ar_burst <= '0;
         r_ready  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (m0_req || m1_req) begin
                  gnt     <= gnt_nxt;
                  dev     <= sel_dev;
                  err_acc <= 1'b0;
                  cnt     <= '0;
                  rbuf    <= '0;
                  wbuf    <= sel_wdata;
                  if (sel_wen) begin
                     aw_valid <= 1'b1;
                     aw_addr  <= ax_addr;
                     aw_id    <= ID_W'(gnt_nxt);
                     aw_len   <= ax_len;
                     aw_size  <= ax_size;
                     aw_burst <= 2'b01;
                     w_strb   <= sel_dev ? sel_wstrb : 8'hFF;
                     state    <= S_AW;
                  end else begin
                     ar_valid <= 1'b1;
                     ar_addr  <= ax_addr;
                     ar_id    <= ID_W'(gnt_nxt);
                     ar_len   <= ax_len;
                     ar_size  <= ax_size;
                     ar_burst <= 2'b01;
                     state    <= S_AR;
                  end
               end
            end
            S_AR: begin
               if (ar_ready) begin
                  ar_valid <= 1'b0;
                  r_ready  <= 1'b1;
                  state    <= S_R;
               end
            end
            S_R: begin
               if (r_valid) begin
                  rbuf    <= rbuf_nxt;
                  err_acc <= err_acc | r_resp[1];
                  if (cnt < 8'(LINE_BEATS)) cnt <= cnt + 8'd1;
                  if (r_last) begin
                     r_ready <= 1'b0;
                     state   <= S_DONE;
                     if (gnt) begin
                        m1_done  <= 1'b1;
                        m1_err   <= err_acc | r_resp[1];
                        m1_rdata <= dev ? {64'd0, rbuf_nxt[63:0]} : rbuf_nxt;
                     end else begin
                        m0_done  <= 1'b1;
                        m0_err   <= err_acc | r_resp[1];
                        m0_rdata <= dev ? {64'd0, rbuf_nxt[63:0]} : rbuf_nxt;
                     end
                  end
               end
            end
            S_AW: begin
               if (aw_ready) begin
                  aw_valid <= 1'b0;
                  w_valid  <= 1'b1;
                  w_data   <= wbuf[63:0];
                  wbuf     <= wbuf >> 64;
                  w_last   <= dev || (LINE_BEATS == 1);
                  cnt      <= 8'd1;
                  state    <= S_W;
               end
            end
            S_W: begin
               if (w_ready) begin
                  if (w_last) begin
                     w_valid <= 1'b0;
                     w_last  <= 1'b0;
                     b_ready <= 1'b1;
                     state   <= S_B;
                  end else begin
                     w_data <= wbuf[63:0];
                     wbuf   <= wbuf >> 64;
                     w_last <= (cnt == 8'(LINE_BEATS - 1));
                     cnt    <= cnt + 8'd1;
                  end
               end
            end
            S_B: begin
               if (b_valid) begin
                  b_ready <= 1'b0;
                  state   <= S_DONE;
                  if (gnt) begin
                     m1_done <= 1'b1;
                     m1_err  <= err_acc | b_resp[1];
                  end else begin
                     m0_done <= 1'b1;
                     m0_err  <= err_acc | b_resp[1];
                  end
               end
            end
            S_DONE: begin
               m0_done <= 1'b0;
               m1_done <= 1'b0;
               m0_err  <= 1'b0;
               m1_err  <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// tb_axi_rw_arbiter: randomized bench for axi_rw_arbiter. A behavioural AXI
// slave with randomized ready/valid delays and error injection serves the
// DUT; expected bus fields, read data, write beats, error flags, grant
// order and latencies are computed from the arbiter's rules.
`timescale 1ns/1ps
module tb_axi_rw_arbiter;
   localparam int LB  = 2;
   localparam int IDW = 4;

   logic clk = 1'b0;
   logic rst;
   logic m0_req, m0_wen, m0_dev, m1_req, m1_wen, m1_dev;
   logic [2:0] m0_size, m1_size;
   logic [31:0] m0_addr, m1_addr;
   logic [127:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
   logic [7:0] m0_wstrb, m1_wstrb;
   logic m0_done, m1_done, m0_err, m1_err;
   logic aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
   logic ar_valid, ar_ready, r_valid, r_ready, r_last;
   logic [31:0] aw_addr, ar_addr;
   logic [IDW-1:0] aw_id, ar_id;
   logic [7:0] aw_len, ar_len, w_strb;
   logic [2:0] aw_size, ar_size;
   logic [1:0] aw_burst, ar_burst, b_resp, r_resp;
   logic [63:0] w_data, r_data;

   axi_rw_arbiter #(.LINE_BEATS(LB), .ID_W(IDW)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_wen(m0_wen), .m0_dev(m0_dev), .m0_size(m0_size),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_wen(m1_wen), .m1_dev(m1_dev), .m1_size(m1_size),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
      .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
      .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // memory contents seen by reads: a fixed function of the 64-bit word index
   function automatic logic [63:0] mdat(input logic [31:0] wa);
      return {wa ^ 32'hA5C3_0F1E, wa * 32'h9E37_79B9};
   endfunction

   function automatic logic outs_any();
      return |{aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, w_valid, w_data, w_strb,
               w_last, b_ready, ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready,
               m0_done, m1_done, m0_rdata, m1_rdata, m0_err, m1_err};
   endfunction

   // expectations for the transaction in flight
   logic [31:0] exp_addr;
   logic [7:0]  exp_len;
   logic [2:0]  exp_size;
   logic [IDW-1:0] exp_id;
   logic        exp_wen;
   logic        exp_err;
   bit          lg_model = 1'b1;   // last granted port, for round-robin ties

   // slave knobs and logs
   int dly_max = 0;     // random ready/valid delay range
   int aw_fix  = -1;    // >=0: fixed AW ready delay
   int w_fix   = -1;    // >=0: fixed W ready delay for subsequent beats
   int err_mode = 0;    // 0 none, 1 random, 2 force SLVERR on beat 1
   bit spur = 0;
   int ar_cnt, ar_dly, aw_cnt, aw_dly, w_cnt, w_dly, r_cnt, r_dly, b_cnt, b_dly;
   int n_ar, n_aw, aw_vcnt;
   bit rd_act, b_pend, r_ready_p, b_ready_p;
   logic [31:0] rd_wa;
   int rd_beat, rd_len;
   logic [63:0] wq[$];
   logic [7:0]  sq[$];
   logic        lq[$];

   function automatic int pick(input int fix);
      if (fix >= 0) return fix;
      return (dly_max > 0) ? int'($urandom_range(0, dly_max)) : 0;
   endfunction

   function automatic logic [1:0] pick_resp(input int beat);
      if (err_mode == 2) return (beat == 1) ? 2'b10 : 2'b00;
      if (err_mode == 1 && $urandom_range(0, 5) == 0) return {1'b1, 1'($urandom_range(0, 1))};
      return {1'b0, 1'($urandom_range(0, 1))};
   endfunction

   // behavioural AXI slave: drives on the falling edge, DUT samples on the rising edge
   initial begin
      ar_ready = 0; aw_ready = 0; w_ready = 0; r_valid = 0; r_data = 0; r_resp = 0;
      r_last = 0; b_valid = 0; b_resp = 0; rd_act = 0; b_pend = 0;
      r_ready_p = 0; b_ready_p = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ar_ready = 0; aw_ready = 0; w_ready = 0; r_valid = 0; r_last = 0; b_valid = 0;
            rd_act = 0; b_pend = 0; r_ready_p = 0; b_ready_p = 0;
            continue;
         end
         // read address: ready raised while valid is held means a handshake this edge
         ar_ready = 0;
         if (ar_valid) begin
            if (ar_cnt >= ar_dly) begin
               ar_ready = 1; n_ar++;
               chk("ar_dir", exp_wen, 1'b0);
               chk("ar_addr", ar_addr, exp_addr);
               chk("ar_len", ar_len, exp_len);
               chk("ar_size", ar_size, exp_size);
               chk("ar_burst", ar_burst, 2'b01);
               chk("ar_id", ar_id, exp_id);
               rd_act = 1; rd_wa = ar_addr >> 3; rd_beat = 0; rd_len = int'(ar_len);
               r_cnt = 0; r_dly = pick(-1); ar_cnt = 0; ar_dly = pick(-1);
            end else ar_cnt++;
         end
         // read data
         if (r_valid && r_ready_p && rd_act) begin
            if (r_last) rd_act = 0;
            rd_beat++; r_valid = 0; r_last = 0;
         end
         if (spur) begin
            r_valid = 1; r_last = 1; r_resp = 2'b10; r_data = 64'hDEAD_BEEF_0BAD_F00D;
         end else if (!rd_act) begin
            r_valid = 0; r_last = 0;
         end else if (!r_valid) begin
            if (r_cnt >= r_dly) begin
               r_valid = 1; r_data = mdat(rd_wa + 32'(rd_beat)); r_last = (rd_beat == rd_len);
               r_resp = pick_resp(rd_beat); exp_err = exp_err | r_resp[1];
               r_cnt = 0; r_dly = pick(-1);
            end else r_cnt++;
         end
         r_ready_p = r_ready;
         // write address
         aw_ready = 0;
         if (aw_valid) begin
            aw_vcnt++;
            if (aw_cnt >= aw_dly) begin
               aw_ready = 1; n_aw++;
               chk("aw_dir", exp_wen, 1'b1);
               chk("aw_addr", aw_addr, exp_addr);
               chk("aw_len", aw_len, exp_len);
               chk("aw_size", aw_size, exp_size);
               chk("aw_burst", aw_burst, 2'b01);
               chk("aw_id", aw_id, exp_id);
               aw_cnt = 0; aw_dly = pick(aw_fix);
            end else aw_cnt++;
         end
         // write response, presented only after the last W handshake
         if (b_valid && b_ready_p) b_valid = 0;
         if (!b_valid && b_pend) begin
            if (b_cnt >= b_dly) begin
               b_valid = 1; b_resp = pick_resp(0); exp_err = exp_err | b_resp[1]; b_pend = 0;
            end else b_cnt++;
         end
         b_ready_p = b_ready;
         // write data
         w_ready = 0;
         if (w_valid) begin
            if (w_cnt >= w_dly) begin
               w_ready = 1;
               wq.push_back(w_data); sq.push_back(w_strb); lq.push_back(w_last);
               if (w_last) begin b_pend = 1; b_cnt = 0; b_dly = pick(-1); end
               w_cnt = 0; w_dly = pick(w_fix);
            end else w_cnt++;
         end
      end
   end

   task automatic set_exp(input bit p, input bit wen, input bit dev, input logic [2:0] sz,
                          input logic [31:0] a);
      exp_addr = dev ? a : {a[31:4], 4'h0};
      exp_len  = dev ? 8'd0 : 8'(LB - 1);
      exp_size = dev ? sz : 3'd3;
      exp_id   = IDW'(p);
      exp_wen  = wen;
      exp_err  = 0;
   endtask

   task automatic drive(input bit p, input bit req, input bit wen, input bit dev,
                        input logic [2:0] sz, input logic [31:0] a, input logic [127:0] wd,
                        input logic [7:0] st);
      if (p) begin
         m1_req = req; m1_wen = wen; m1_dev = dev; m1_size = sz; m1_addr = a;
         m1_wdata = wd; m1_wstrb = st;
      end else begin
         m0_req = req; m0_wen = wen; m0_dev = dev; m0_size = sz; m0_addr = a;
         m0_wdata = wd; m0_wstrb = st;
      end
   endtask

   function automatic logic [127:0] exp_rd(input logic [31:0] xa, input bit dev);
      return dev ? {64'd0, mdat(xa >> 3)} : {mdat((xa >> 3) + 1), mdat(xa >> 3)};
   endfunction

   // one complete single-requester transaction with full result checking
   task automatic xfer(input bit p, input bit wen, input bit dev, input logic [2:0] sz,
                       input logic [31:0] a, input logic [127:0] wd, input logic [7:0] st,
                       output int lat);
      int t0;
      bit seen;
      int nb;
      @(negedge clk);
      set_exp(p, wen, dev, sz, a);
      wq.delete(); sq.delete(); lq.delete();
      n_ar = 0; n_aw = 0; aw_vcnt = 0;
      ar_cnt = 0; ar_dly = pick(-1); aw_cnt = 0; aw_dly = pick(aw_fix);
      w_cnt = 0; w_dly = pick(-1);
      drive(p, 1'b1, wen, dev, sz, a, wd, st);
      t0 = cyc; seen = 0; lat = -1;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (p ? m1_done : m0_done) seen = 1;
      end
      chk("done_seen", seen, 1'b1);
      lat = cyc - t0;
      lg_model = p;
      chk("done_other", p ? m0_done : m1_done, 1'b0);
      chk("err", p ? m1_err : m0_err, exp_err);
      if (!wen) chk("rdata", p ? m1_rdata : m0_rdata, exp_rd(exp_addr, dev));
      chk("n_ax", wen ? n_aw : n_ar, 1);
      chk("n_ax_other", wen ? n_ar : n_aw, 0);
      if (wen) begin
         nb = dev ? 1 : LB;
         chk("w_beats", wq.size(), nb);
         for (int k = 0; k < nb && k < wq.size(); k++) begin
            chk("w_data", wq[k], wd[k*64 +: 64]);
            chk("w_strb", sq[k], dev ? st : 8'hFF);
            chk("w_last", lq[k], k == nb - 1);
         end
      end
      drive(p, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 128'd0, 8'd0);
      @(negedge clk);
      chk("done_pulse", p ? m1_done : m0_done, 1'b0);
   endtask

   int lat;
   logic [127:0] rw;

   initial begin
      rst = 1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      ar_cnt = 0; ar_dly = 0; aw_cnt = 0; aw_dly = 0; w_cnt = 0; w_dly = 0;
      exp_err = 0; exp_wen = 0; exp_addr = 0; exp_len = 0; exp_size = 0; exp_id = 0;
      n_ar = 0; n_aw = 0; aw_vcnt = 0;
      repeat (3) @(negedge clk);
      chk("reset_outs", outs_any(), 1'b0);
      rst = 0;

      // best-case line read on m0, unaligned address
      xfer(0, 0, 0, 3'd0, 32'h8000_0014, 128'd0, 8'd0, lat);
      chk("lat_line_rd", lat, 4);

      // best-case line write on m0
      rw = {$urandom, $urandom, $urandom, $urandom};
      xfer(0, 1, 0, 3'd0, 32'h8000_0128, rw, 8'h00, lat);
      chk("lat_line_wr", lat, 5);

      // device write on m1 with AW ready held off for 3 cycles
      aw_fix = 3;
      xfer(1, 1, 1, 3'd2, 32'hA000_03F8, {64'h0, 64'h1122_3344_5566_7788}, 8'h0F, lat);
      chk("aw_hold", aw_vcnt, 4);
      aw_fix = -1;

      // SLVERR on beat 1 of a line read, then a clean transaction
      err_mode = 2;
      xfer(1, 0, 0, 3'd0, 32'h0000_4440, 128'd0, 8'd0, lat);
      chk("err_forced", m1_err, 1'b0);   // cleared the cycle after done
      err_mode = 0;
      xfer(1, 0, 1, 3'd3, 32'h0000_4448, 128'd0, 8'd0, lat);

      // spurious r_valid while idle
      spur = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("spur_rready", r_ready, 1'b0);
         chk("spur_done", m0_done | m1_done, 1'b0);
      end
      spur = 0;
      @(negedge clk);

      // both ports request continuously for three grants
      begin
         bit w, got;
         @(negedge clk);
         drive(0, 1, 0, 0, 3'd0, 32'h0000_1000, 128'd0, 8'd0);
         drive(1, 1, 0, 0, 3'd0, 32'h0000_2000, 128'd0, 8'd0);
         for (int r = 0; r < 3; r++) begin
`ifdef AXI_ARB_RR_EN
            w = ~lg_model;
`else
            w = 1'b1;
`endif
            lg_model = w;
            set_exp(w, 0, 0, 3'd0, w ? 32'h0000_2000 : 32'h0000_1000);
            got = 0;
            for (int i = 0; i < 300 && !got; i++) begin
               @(negedge clk);
               got = m0_done | m1_done;
            end
            chk("tie_done", got, 1'b1);
            chk("tie_gnt", m1_done, w);
            chk("tie_rdata", w ? m1_rdata : m0_rdata, exp_rd(exp_addr, 0));
         end
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         drive(1, 0, 0, 0, 0, 0, 0, 0);
         repeat (2) @(negedge clk);
      end

      // reset while the second write beat is stalled
      begin
         bit got;
         @(negedge clk);
         set_exp(0, 1, 0, 3'd0, 32'h0000_3000);
         wq.delete(); sq.delete(); lq.delete();
         ar_cnt = 0; aw_cnt = 0; aw_dly = 0; w_cnt = 0; w_dly = 0; w_fix = 50;
         drive(0, 1, 1, 0, 3'd0, 32'h0000_3000, {$urandom, $urandom, $urandom, $urandom}, 8'h0);
         got = 0;
         for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = (wq.size() == 1);
         end
         chk("rst_wbeat", got, 1'b1);
         repeat (2) @(negedge clk);
         chk("rst_in_w", w_valid, 1'b1);
         rst = 1;
         #1;
         chk("rst_outs", outs_any(), 1'b0);
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         w_fix = -1;
         @(negedge clk);
         chk("rst_nodone", m0_done | m1_done, 1'b0);
         @(negedge clk);
         rst = 0;
         lg_model = 1'b1;
         dly_max = 3;
         xfer(0, 0, 0, 3'd0, 32'h0000_5560, 128'd0, 8'd0, lat);
      end

      // randomized single-requester traffic
      err_mode = 1;
      for (int n = 0; n < 30; n++) begin
         xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 3)), $urandom, {$urandom, $urandom, $urandom, $urandom},
              8'($urandom), lat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
